// File: rtl/dm_resp.sv
// Data-memory responder: handshaked load/store engine over an internal
// byte-enabled word RAM, with one-cycle response pulse.
// Optional feature macro: MISALIGN_SPLIT_EN -- when defined, misaligned H/W
// accesses are split across two adjacent words (ACC0 + ACC1, index wraps);
// when undefined, misaligned H/W accesses complete as errors.
module dm_resp #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        dm_read,
    input  logic        dm_write,
    input  logic [2:0]  dmop,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        err
);

    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // Storage; contents survive reset.
    logic [31:0] mem [DEPTH];

    // Latched request
    logic [AW-1:0] idx_q;
    logic [1:0]    off_q;
    logic [2:0]    op_q;
    logic          wr_q;
    logic          bad_q;
    logic [31:0]   wdata_q;

    // Acceptance decode
    logic          fire;
    logic          is_h;
    logic          is_w;
    logic          op_bad;
    logic          dir_bad;
    logic          uns_wr;
    logic          acc_bad;
    logic [29:0]   widx;
    logic [AW-1:0] idx_d;

    // RAM port
    logic          mem_we;
    logic [3:0]    mem_be;
    logic [31:0]   mem_wd;
    logic [AW-1:0] mem_idx;
    logic [31:0]   mem_rdata;

    // Lane mapping / load path
    logic [3:0]    sz_mask;
    logic [31:0]   rd_raw;
    logic [31:0]   ld_ext;

    // Registered-output next values
    logic          req_ready_d;
    logic          resp_valid_d;
    logic [31:0]   rdata_d;
    logic          err_d;

`ifdef MISALIGN_SPLIT_EN
    logic          split_d;
    logic          split_q;
    logic [31:0]   rd_lo_q;
    logic [7:0]    be_w;
    logic [63:0]   wd_w;
    logic [63:0]   rd_w;
    logic [AW-1:0] idx_inc;
`else
    logic          misal;
    logic [3:0]    be_w;
    logic [31:0]   wd_w;
`endif

    assign fire = (state == IDLE) && req_valid;

    // Classify the incoming request: legality, word index and split need.
    always_comb begin
        is_h    = (dmop[1:0] == 2'b01);
        is_w    = (dmop[1:0] == 2'b10);
        op_bad  = (dmop == 3'b011) || (dmop == 3'b110) || (dmop == 3'b111);
        dir_bad = (dm_read == dm_write);
        uns_wr  = dm_write && dmop[2];
        widx    = addr[31:2] % 30'(DEPTH);
        idx_d   = AW'(widx);
`ifdef MISALIGN_SPLIT_EN
        acc_bad = op_bad || dir_bad || uns_wr;
        split_d = !acc_bad &&
                  ((is_h && (addr[1:0] == 2'b11)) || (is_w && (addr[1:0] != 2'b00)));
`else
        misal   = (is_h && addr[0]) || (is_w && (addr[1:0] != 2'b00));
        acc_bad = op_bad || dir_bad || uns_wr || misal;
`endif
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; errors still pass through ACC0 (no RAM access) so
    // every unsplit request has the same latency.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req_valid) state_nxt = ACC0;
`ifdef MISALIGN_SPLIT_EN
            ACC0: state_nxt = split_q ? ACC1 : RESP;
            ACC1: state_nxt = RESP;
`else
            ACC0: state_nxt = RESP;
`endif
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the request at the handshake edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx_q   <= '0;
            off_q   <= '0;
            op_q    <= '0;
            wr_q    <= 1'b0;
            bad_q   <= 1'b0;
            wdata_q <= '0;
`ifdef MISALIGN_SPLIT_EN
            split_q <= 1'b0;
`endif
        end else if (fire) begin
            idx_q   <= idx_d;
            off_q   <= addr[1:0];
            op_q    <= dmop;
            wr_q    <= dm_write;
            bad_q   <= acc_bad;
            wdata_q <= wdata;
`ifdef MISALIGN_SPLIT_EN
            split_q <= split_d;
`endif
        end
    end

`ifdef MISALIGN_SPLIT_EN
    // Hold the first-word read while the second word is fetched.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_lo_q <= '0;
        end else if (state == ACC0) begin
            rd_lo_q <= mem_rdata;
        end
    end
`endif

    // Byte-lane mapping of the access across one (or two) words.
    always_comb begin
        case (op_q[1:0])
            2'b00:   sz_mask = 4'b0001;
            2'b01:   sz_mask = 4'b0011;
            default: sz_mask = 4'b1111;
        endcase
`ifdef MISALIGN_SPLIT_EN
        be_w    = 8'(sz_mask) << off_q;
        wd_w    = 64'(wdata_q) << {off_q, 3'b000};
        idx_inc = (idx_q == AW'(DEPTH - 1)) ? '0 : idx_q + AW'(1);
`else
        be_w    = sz_mask << off_q;
        wd_w    = wdata_q << {off_q, 3'b000};
`endif
    end

    // RAM word select: second word of a split lives at index+1.
`ifdef MISALIGN_SPLIT_EN
    assign mem_idx = (state == ACC1) ? idx_inc : idx_q;
`else
    assign mem_idx = idx_q;
`endif
    assign mem_rdata = mem[mem_idx];

    // RAM write strobes for the current access phase.
    always_comb begin
        mem_we = 1'b0;
        mem_be = '0;
        mem_wd = '0;
        case (state)
            ACC0: begin
                mem_we = wr_q && !bad_q;
                mem_be = be_w[3:0];
                mem_wd = wd_w[31:0];
            end
`ifdef MISALIGN_SPLIT_EN
            ACC1: begin
                mem_we = wr_q && !bad_q;
                mem_be = be_w[7:4];
                mem_wd = wd_w[63:32];
            end
`endif
            default: ;
        endcase
    end

    // Byte-enabled RAM write.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b]) begin
                    mem[mem_idx][8*b +: 8] <= mem_wd[8*b +: 8];
                end
            end
        end
    end

    // Little-endian byte assembly followed by sign/zero extension.
    always_comb begin
`ifdef MISALIGN_SPLIT_EN
        rd_w   = (state == ACC1) ? {mem_rdata, rd_lo_q} : {32'h0, mem_rdata};
        rd_raw = 32'(rd_w >> {off_q, 3'b000});
`else
        rd_raw = mem_rdata >> {off_q, 3'b000};
`endif
        case (op_q)
            OP_B:    ld_ext = {{24{rd_raw[7]}}, rd_raw[7:0]};
            OP_H:    ld_ext = {{16{rd_raw[15]}}, rd_raw[15:0]};
            OP_BU:   ld_ext = {24'h0, rd_raw[7:0]};
            OP_HU:   ld_ext = {16'h0, rd_raw[15:0]};
            OP_W:    ld_ext = rd_raw;
            default: ld_ext = rd_raw;
        endcase
    end

    // Output next-values: response payload is formed on the edge into RESP.
    always_comb begin
        req_ready_d  = (state_nxt == IDLE);
        resp_valid_d = 1'b0;
        rdata_d      = '0;
        err_d        = 1'b0;
        if (state_nxt == RESP) begin
            resp_valid_d = 1'b1;
            err_d        = bad_q;
            rdata_d      = (bad_q || wr_q) ? 32'h0 : ld_ext;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            rdata      <= '0;
            err        <= 1'b0;
        end else begin
            req_ready  <= req_ready_d;
            resp_valid <= resp_valid_d;
            rdata      <= rdata_d;
            err        <= err_d;
        end
    end

endmodule

// File: tb/tb_dm_resp.sv
// Self-checking bench for dm_resp: table-driven loads/stores plus a
// reset-during-access sequence. Expectations follow MISALIGN_SPLIT_EN.
module tb_dm_resp;

`ifdef MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif
    localparam int LMIS = SPLIT ? 3 : 2;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        dm_read = 1'b0;
    logic        dm_write = 1'b0;
    logic [2:0]  dmop = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        resp_valid;
    logic [31:0] rdata;
    logic        err;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    dm_resp #(.DEPTH(1024), .AW(10)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .dm_read    (dm_read),
        .dm_write   (dm_write),
        .dmop       (dmop),
        .addr       (addr),
        .wdata      (wdata),
        .resp_valid (resp_valid),
        .rdata      (rdata),
        .err        (err)
    );

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          lat;
    } vec_t;

    vec_t vecs[$];
    vec_t post[$];

    function automatic vec_t ld(string n, logic [2:0] op, logic [31:0] a,
                                logic [31:0] e, logic ee, int lat);
        ld = '{n, 1'b1, 1'b0, op, a, 32'h0, e, ee, lat};
    endfunction

    function automatic vec_t st(string n, logic [2:0] op, logic [31:0] a,
                                logic [31:0] wd, logic ee, int lat);
        st = '{n, 1'b0, 1'b1, op, a, wd, 32'h0, ee, lat};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // One request; a junk store is held on the bus while busy and must be ignored.
    task automatic run_vec(input vec_t v);
        @(negedge clk);
        dm_read = v.rd; dm_write = v.wr; dmop = v.op; addr = v.addr; wdata = v.wdata;
        req_valid = 1'b1;
        chk({v.name, " ready_in"}, 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        dm_read = 1'b0; dm_write = 1'b1; dmop = 3'b010; wdata = 32'h5A5A5A5A;
        for (int c = 1; c <= v.lat + 1; c++) begin
            @(negedge clk);
            if (c == v.lat) begin
                chk({v.name, " resp_valid"}, 32'(resp_valid), 32'h1);
                chk({v.name, " rdata"}, rdata, v.exp_rdata);
                chk({v.name, " err"}, 32'(err), 32'(v.exp_err));
                req_valid = 1'b0;
            end else if (c < v.lat) begin
                chk({v.name, " early_resp"}, 32'(resp_valid), 32'h0);
                chk({v.name, " busy_ready"}, 32'(req_ready), 32'h0);
            end else begin
                chk({v.name, " resp_end"}, 32'(resp_valid), 32'h0);
                chk({v.name, " ready_back"}, 32'(req_ready), 32'h1);
                chk({v.name, " rdata_idle"}, rdata, 32'h0);
                chk({v.name, " err_idle"}, 32'(err), 32'h0);
            end
        end
    endtask

    initial begin
        // Aligned loads/stores and extension
        vecs.push_back(st("sw10",  3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 2));
        vecs.push_back(ld("lw10",  3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 2));
        vecs.push_back(st("sw10z", 3'b010, 32'h10, 32'h00000000, 1'b0, 2));
        vecs.push_back(st("sb11",  3'b000, 32'h11, 32'h00000080, 1'b0, 2));
        vecs.push_back(ld("lb11",  3'b000, 32'h11, 32'hFFFFFF80, 1'b0, 2));
        vecs.push_back(ld("lbu11", 3'b100, 32'h11, 32'h00000080, 1'b0, 2));
        vecs.push_back(ld("lw10b", 3'b010, 32'h10, 32'h00008000, 1'b0, 2));
        vecs.push_back(st("sh12",  3'b001, 32'h12, 32'h1234ABCD, 1'b0, 2));
        vecs.push_back(ld("lh12",  3'b001, 32'h12, 32'hFFFFABCD, 1'b0, 2));
        vecs.push_back(ld("lhu12", 3'b101, 32'h12, 32'h0000ABCD, 1'b0, 2));
        vecs.push_back(ld("lw10c", 3'b010, 32'h10, 32'hABCD8000, 1'b0, 2));
        vecs.push_back(ld("lh10",  3'b001, 32'h10, 32'hFFFF8000, 1'b0, 2));
        vecs.push_back(ld("lb10",  3'b000, 32'h10, 32'h00000000, 1'b0, 2));
        // Illegal requests
        vecs.push_back(ld("op011", 3'b011, 32'h10, 32'h0, 1'b1, 2));
        vecs.push_back(ld("op110", 3'b110, 32'h10, 32'h0, 1'b1, 2));
        vecs.push_back(ld("op111", 3'b111, 32'h10, 32'h0, 1'b1, 2));
        vecs.push_back('{"rdwr", 1'b1, 1'b1, 3'b010, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b1, 2});
        vecs.push_back('{"norw", 1'b0, 1'b0, 3'b010, 32'h10, 32'hFFFFFFFF, 32'h0, 1'b1, 2});
        vecs.push_back(st("sbu",   3'b100, 32'h10, 32'hFFFFFFFF, 1'b1, 2));
        vecs.push_back(st("shu",   3'b101, 32'h10, 32'hFFFFFFFF, 1'b1, 2));
        vecs.push_back(ld("lw10d", 3'b010, 32'h10, 32'hABCD8000, 1'b0, 2));
        // Misaligned, including wrap from the last word to word 0
        vecs.push_back(st("swffc", 3'b010, 32'hFFC, 32'h0, 1'b0, 2));
        vecs.push_back(st("sw000", 3'b010, 32'h000, 32'h0, 1'b0, 2));
        vecs.push_back(st("swffd", 3'b010, 32'hFFD, 32'h11223344, !SPLIT, LMIS));
        vecs.push_back(ld("lwffd", 3'b010, 32'hFFD, SPLIT ? 32'h11223344 : 32'h0, !SPLIT, LMIS));
        vecs.push_back(ld("lwffc", 3'b010, 32'hFFC, SPLIT ? 32'h22334400 : 32'h0, 1'b0, 2));
        vecs.push_back(ld("lw000", 3'b010, 32'h000, SPLIT ? 32'h00000011 : 32'h0, 1'b0, 2));
        vecs.push_back(ld("lbufff", 3'b100, 32'hFFF, SPLIT ? 32'h00000022 : 32'h0, 1'b0, 2));
        vecs.push_back(st("sw20",  3'b010, 32'h20, 32'h0, 1'b0, 2));
        vecs.push_back(st("sh21",  3'b001, 32'h21, 32'h0000BEEF, !SPLIT, 2));
        vecs.push_back(ld("lw20",  3'b010, 32'h20, SPLIT ? 32'h00BEEF00 : 32'h0, 1'b0, 2));
        vecs.push_back(ld("lh21",  3'b001, 32'h21, SPLIT ? 32'hFFFFBEEF : 32'h0, !SPLIT, 2));
        vecs.push_back(st("sw24",  3'b010, 32'h24, 32'h0, 1'b0, 2));
        vecs.push_back(st("sh23",  3'b001, 32'h23, 32'h00007788, !SPLIT, LMIS));
        vecs.push_back(ld("lh23",  3'b001, 32'h23, SPLIT ? 32'h00007788 : 32'h0, !SPLIT, LMIS));
        vecs.push_back(ld("lw24",  3'b010, 32'h24, SPLIT ? 32'h00000077 : 32'h0, 1'b0, 2));
        vecs.push_back(ld("lw20b", 3'b010, 32'h20, SPLIT ? 32'h88BEEF00 : 32'h0, 1'b0, 2));
        vecs.push_back(ld("lw22",  3'b010, 32'h22, SPLIT ? 32'h007788BE : 32'h0, !SPLIT, LMIS));
        // Setup for the reset-abort sequence
        vecs.push_back(st("sw30",  3'b010, 32'h30, 32'h0, 1'b0, 2));
        vecs.push_back(st("sw34",  3'b010, 32'h34, 32'h0, 1'b0, 2));

        post.push_back(ld("rst_lw30", 3'b010, 32'h30, SPLIT ? 32'hF00D0000 : 32'h0, 1'b0, 2));
        post.push_back(ld("rst_lw34", 3'b010, 32'h34, 32'h0, 1'b0, 2));
        post.push_back(st("rst_sw38", 3'b010, 32'h38, 32'h600DCAFE, 1'b0, 2));
        post.push_back(ld("rst_lw38", 3'b010, 32'h38, 32'h600DCAFE, 1'b0, 2));

        // Power-on reset values
        #2 rstn = 1'b0;
        #1;
        chk("rst_ready", 32'(req_ready), 32'h1);
        chk("rst_resp",  32'(resp_valid), 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_err",   32'(err), 32'h0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset in the second access phase (split) or first phase (unsplit)
        @(negedge clk);
        dm_read = 1'b0; dm_write = 1'b1; dmop = 3'b010;
        addr = SPLIT ? 32'h32 : 32'h30; wdata = 32'hCAFEF00D;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (SPLIT ? 2 : 1) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("abort_ready", 32'(req_ready), 32'h1);
        chk("abort_resp",  32'(resp_valid), 32'h0);
        chk("abort_rdata", rdata, 32'h0);
        chk("abort_err",   32'(err), 32'h0);
        @(negedge clk);
        rstn = 1'b1;

        foreach (post[i]) run_vec(post[i]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
